// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Registers the ALU operands, captures result/flags, returns them on a valid/ready channel.
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic [N-1:0] alu_src1,
  output logic [N-1:0] alu_src2,
  output logic [1:0]   alu_ctrl,
  input  logic [N-1:0] alu_num,
  input  logic [3:0]   alu_flags,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_num,
  output logic [3:0]   rsp_flags,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_grant;
  logic   w_grant;
  logic   w_accept;

  // Contention goes to whoever did not win last time; reset value 1 favours requester 0.
  always_comb begin
    w_grant = 1'b0;
    if (req_valid == 2'b11) w_grant = ~r_last_grant;
    else if (req_valid[1])  w_grant = 1'b1;
  end

  assign w_accept = (r_state == IDLE) && (|req_valid);
  assign busy     = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          req_ready = w_grant ? 2'b10 : 2'b01;
          w_next    = EXEC;
        end
      end
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      alu_src1     <= '0;
      alu_src2     <= '0;
      alu_ctrl     <= 2'b00;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_num      <= '0;
      rsp_flags    <= 4'b0000;
    end else begin
      if (w_accept) begin
        alu_src1     <= w_grant ? req1_a  : req0_a;
        alu_src2     <= w_grant ? req1_b  : req0_b;
        alu_ctrl     <= w_grant ? req1_op : req0_op;
        r_last_grant <= w_grant;
      end
      // ALU operands have been stable for the whole EXEC cycle; sample its output now.
      if (r_state == EXEC) begin
        rsp_num   <= alu_num;
        rsp_flags <= alu_flags;
        rsp_id    <= r_last_grant;
        rsp_valid <= 1'b1;
      end else if ((r_state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU model, table of single ops, multi-cycle sequences.
module tb_alu_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_op, req1_op;
  logic [N-1:0] alu_src1, alu_src2;
  logic [1:0]   alu_ctrl;
  logic [N-1:0] alu_num;
  logic [3:0]   alu_flags;
  logic         rsp_valid, rsp_ready, rsp_id, busy;
  logic [N-1:0] rsp_num;
  logic [3:0]   rsp_flags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_num(alu_num), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_num(rsp_num), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational ALU: flags {neg, cero, carry, des}; sub returns magnitude with sign in neg.
  logic [N:0]   m_sum;
  logic [N-1:0] m_num;
  logic         m_neg, m_carry, m_des;
  always_comb begin
    m_sum   = '0;
    m_num   = '0;
    m_neg   = 1'b0;
    m_carry = 1'b0;
    m_des   = 1'b0;
    case (alu_ctrl)
      2'b00: begin
        m_sum   = {1'b0, alu_src1} + {1'b0, alu_src2};
        m_num   = m_sum[N-1:0];
        m_carry = m_sum[N];
        m_des   = (alu_src1[N-1] == alu_src2[N-1]) && (m_num[N-1] != alu_src1[N-1]);
        m_neg   = m_num[N-1];
      end
      2'b01: begin
        if (alu_src1 < alu_src2) begin
          m_num = alu_src2 - alu_src1;
          m_neg = 1'b1;
        end else begin
          m_num = alu_src1 - alu_src2;
        end
      end
      2'b10: begin
        m_num = alu_src1 & alu_src2;
        m_neg = m_num[N-1];
      end
      default: begin
        m_num = alu_src1 | alu_src2;
        m_neg = m_num[N-1];
      end
    endcase
  end
  assign alu_num   = m_num;
  assign alu_flags = {m_neg, (m_num == '0), m_carry, m_des};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   op;
    logic [N-1:0] exp_num;
    logic [3:0]   exp_flags;
  } vec_t;

  vec_t vec [8];

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_req(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [1:0] op);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int k;
    @(negedge clk);
    drive_req(v.id, v.a, v.b, v.op);
    req_valid = v.id ? 2'b10 : 2'b01;
    #1;
    k = 0;
    while (req_ready == 2'b00 && k < 10) begin
      @(negedge clk); #1; k++;
    end
    check($sformatf("v%0d_ready", idx), req_ready, v.id ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check($sformatf("v%0d_exec_valid", idx), rsp_valid, 1'b0);
    check($sformatf("v%0d_src1", idx), alu_src1, v.a);
    check($sformatf("v%0d_ctrl", idx), alu_ctrl, v.op);
    @(negedge clk);
    check($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1'b1);
    check($sformatf("v%0d_rsp_id", idx), rsp_id, v.id);
    check($sformatf("v%0d_rsp_num", idx), rsp_num, v.exp_num);
    check($sformatf("v%0d_rsp_flags", idx), rsp_flags, v.exp_flags);
    @(negedge clk);
    check($sformatf("v%0d_done", idx), {busy, rsp_valid}, 2'b00);
  endtask

  initial begin
    int grants [$];
    int last_cyc;
    int cyc;

    vec[0] = '{1'b0, 32'd5,          32'd3,          2'b00, 32'd8,          4'b0000};
    vec[1] = '{1'b1, 32'd3,          32'd5,          2'b01, 32'd2,          4'b1000};
    vec[2] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          2'b00, 32'd0,          4'b0110};
    vec[3] = '{1'b0, 32'h0000_F0F0,  32'h0000_FF00,  2'b10, 32'h0000_F000,  4'b0000};
    vec[4] = '{1'b1, 32'h0000_0F0F,  32'h0000_F000,  2'b11, 32'h0000_FF0F,  4'b0000};
    vec[5] = '{1'b0, 32'd7,          32'd7,          2'b01, 32'd0,          4'b0100};
    vec[6] = '{1'b1, 32'h7FFF_FFFF,  32'd1,          2'b00, 32'h8000_0000,  4'b1001};
    vec[7] = '{1'b0, 32'h8000_0000,  32'd0,          2'b11, 32'h8000_0000,  4'b1000};

    req0_a = '0; req0_b = '0; req0_op = 2'b00;
    req1_a = '0; req1_b = '0; req1_op = 2'b00;
    do_reset();

    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_num", rsp_num, 32'd0);
    check("rst_rsp_flags", rsp_flags, 4'd0);
    check("rst_alu_src", {alu_src1, alu_src2}, 64'd0);
    check("rst_alu_ctrl", alu_ctrl, 2'b00);
    check("rst_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) run_op(vec[i], i);

    // Round robin with both requesters always valid.
    do_reset();
    @(negedge clk);
    drive_req(1'b0, 32'd1, 32'd1, 2'b00);
    drive_req(1'b1, 32'd2, 32'd2, 2'b00);
    req_valid = 2'b11;
    for (int c = 0; c < 40 && grants.size() < 4; c++) begin
      #1;
      check("rr_onehot", ($countones(req_ready) <= 1), 1'b1);
      if (req_ready != 2'b00) grants.push_back(int'(req_ready[1]));
      if (rsp_valid) check("rr_rsp_num", rsp_num, rsp_id ? 32'd4 : 32'd2);
      @(negedge clk);
    end
    check("rr_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      check($sformatf("rr_grant%0d", i), grants[i], i % 2);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Response stall: consumer not ready for 5 cycles, other requester waiting.
    do_reset();
    rsp_ready = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 32'd5, 32'd3, 2'b00);
    drive_req(1'b1, 32'd9, 32'd1, 2'b01);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b10;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("stall%0d_valid", c), rsp_valid, 1'b1);
      check($sformatf("stall%0d_ready", c), req_ready, 2'b00);
      check($sformatf("stall%0d_num", c), {rsp_flags, rsp_num}, {4'b0000, 32'd8});
      check($sformatf("stall%0d_alu", c), {alu_ctrl, alu_src1, alu_src2}, {2'b00, 32'd5, 32'd3});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("stall_release_valid", rsp_valid, 1'b0);
    check("stall_next_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    check("stall_r1_num", {rsp_id, rsp_num}, {1'b1, 32'd8});
    @(negedge clk);

    // Reset while in EXEC drops the op and restores requester-0 priority.
    do_reset();
    @(negedge clk);
    drive_req(1'b0, 32'd4, 32'd4, 2'b00);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("mid_in_exec", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_src1", alu_src1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_no_rsp", rsp_valid, 1'b0);
    drive_req(1'b0, 32'd10, 32'd1, 2'b01);
    drive_req(1'b1, 32'd20, 32'd1, 2'b01);
    req_valid = 2'b11;
    #1;
    check("mid_grant_r0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    check("mid_rsp", {rsp_valid, rsp_id, rsp_num}, {1'b1, 1'b0, 32'd9});
    @(negedge clk);

    // Back-to-back requester 0: one grant every 3 cycles.
    do_reset();
    @(negedge clk);
    drive_req(1'b0, 32'd10, 32'd20, 2'b00);
    req_valid = 2'b01;
    last_cyc = -1;
    grants.delete();
    cyc = 0;
    while (cyc < 30 && grants.size() < 4) begin
      #1;
      if (req_ready != 2'b00) begin
        check("b2b_ready", req_ready, 2'b01);
        if (last_cyc >= 0) check("b2b_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        grants.push_back(cyc);
      end
      if (rsp_valid) check("b2b_num", {rsp_id, rsp_num}, {1'b0, 32'd30});
      @(negedge clk);
      cyc++;
    end
    check("b2b_count", grants.size(), 4);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
